// File: rtl/serial_le_seq_if.sv
// Request/result bundle for the bit-serial a<=b comparator.
// Handshake: start is honoured only in an idle cycle (busy=0, done=0). Results are valid in the done cycle.
interface serial_le_seq_if #(
   parameter int W = 8
);
   localparam int IW = $clog2(W);

   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic          le_o;
   logic          eq_o;
   logic [IW-1:0] bit_idx;
   logic [1:0]    dbg_state;

   modport master (
      output start, a, b,
      input  busy, done, le_o, eq_o, bit_idx, dbg_state
   );

   modport slave (
      input  start, a, b,
      output busy, done, le_o, eq_o, bit_idx, dbg_state
   );
endinterface

// File: rtl/serial_le_seq.sv
// Sequential MSB-first unsigned comparator: one bit per clock, reports a<=b and a==b with a done pulse.
// EARLY_EXIT selects stop-at-first-difference (variable latency) or a full W-bit scan (fixed latency).
module serial_le_seq #(
   parameter int W          = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_le_seq_if.slave  bus
);
   localparam int IW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [W-1:0]  ra_q, rb_q;
   logic [IW-1:0] idx_q;
   logic          busy_q, done_q, le_q, eq_q;
   logic          dec_q, dle_q;

   logic a_bit, b_bit, differ, decided, last, finish, le_d;

   always_comb begin
      a_bit   = ra_q[idx_q];
      b_bit   = rb_q[idx_q];
      differ  = a_bit ^ b_bit;
      decided = dec_q | differ;
      last    = (idx_q == '0);
      finish  = last | ((EARLY_EXIT != 0) & decided);
      // First differing bit wins; an undecided scan means the operands are equal.
      if (dec_q)       le_d = dle_q;
      else if (differ) le_d = b_bit;
      else             le_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         le_q    <= 1'b0;
         eq_q    <= 1'b0;
         dec_q   <= 1'b0;
         dle_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  ra_q    <= bus.a;
                  rb_q    <= bus.b;
                  idx_q   <= IW'(W - 1);
                  dec_q   <= 1'b0;
                  dle_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (differ && !dec_q) begin
                  dec_q <= 1'b1;
                  dle_q <= b_bit;
               end
               if (finish) begin
                  le_q    <= le_d;
                  eq_q    <= ~decided;
                  done_q  <= 1'b1;
                  idx_q   <= '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.le_o      = le_q;
   assign bus.eq_o      = eq_q;
   assign bus.bit_idx   = idx_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_serial_le_seq.sv
// Directed bench for serial_le_seq: one instance per EARLY_EXIT setting, hand-computed expectations.
module tb_serial_le_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // sel 0: EARLY_EXIT=0, sel 1: EARLY_EXIT=1
   serial_le_seq_if #(.W(8)) if0 ();
   serial_le_seq_if #(.W(8)) if1 ();

   serial_le_seq #(.W(8), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   serial_le_seq #(.W(8), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int   n_total = 0;
   int   n_bad   = 0;
   logic s_busy, s_done, s_le, s_eq;
   logic [2:0] s_idx;
   logic last_le [2];
   logic last_eq [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [7:0] av, input logic [7:0] bv);
      if (sel == 0) begin
         if0.start = st; if0.a = av; if0.b = bv;
      end else begin
         if1.start = st; if1.a = av; if1.b = bv;
      end
   endtask

   task automatic samp(input int sel);
      if (sel == 0) begin
         s_busy = if0.busy; s_done = if0.done; s_le = if0.le_o; s_eq = if0.eq_o; s_idx = if0.bit_idx;
      end else begin
         s_busy = if1.busy; s_done = if1.done; s_le = if1.le_o; s_eq = if1.eq_o; s_idx = if1.bit_idx;
      end
   endtask

   // Called at a negedge in an idle cycle; returns at the negedge of the first idle cycle after done.
   task automatic run_cmp(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input int exp_lat, input logic exp_le, input logic exp_eq,
                          input bit walk, input bit disturb);
      int lat;
      drive(sel, 1'b1, av, bv);
      @(negedge clk);
      lat = 1;
      samp(sel);
      while (!s_done && lat < 20) begin
         chk("busy_scan", 32'(s_busy), 32'd1);
         chk("le_hold", 32'(s_le), 32'(last_le[sel]));
         chk("eq_hold", 32'(s_eq), 32'(last_eq[sel]));
         if (walk) chk("bit_idx_walk", 32'(s_idx), 32'(8 - lat));
         if (disturb) drive(sel, lat == 1, 8'hFF, bv);
         else         drive(sel, 1'b0, ~av, ~bv);
         @(negedge clk);
         lat++;
         samp(sel);
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("le", 32'(s_le), 32'(exp_le));
      chk("eq", 32'(s_eq), 32'(exp_eq));
      chk("busy_done", 32'(s_busy), 32'd1);
      last_le[sel] = exp_le;
      last_eq[sel] = exp_eq;
      drive(sel, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      samp(sel);
      chk("done_pulse", 32'(s_done), 32'd0);
      chk("busy_idle", 32'(s_busy), 32'd0);
      chk("idx_idle", 32'(s_idx), 32'd0);
   endtask

   task automatic count_quiet(input int sel, input string tag);
      int nd;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         samp(sel);
         if (s_done) nd++;
      end
      chk(tag, 32'(nd), 32'd0);
   endtask

   initial begin
      last_le[0] = 1'b0; last_eq[0] = 1'b0;
      last_le[1] = 1'b0; last_eq[1] = 1'b0;
      drive(0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         samp(s);
         chk("rst_busy", 32'(s_busy), 32'd0);
         chk("rst_done", 32'(s_done), 32'd0);
         chk("rst_le", 32'(s_le), 32'd0);
         chk("rst_eq", 32'(s_eq), 32'd0);
         chk("rst_idx", 32'(s_idx), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Reset abort mid-scan
      drive(0, 1'b1, 8'h80, 8'h7F);
      @(negedge clk);
      drive(0, 1'b0, 8'h80, 8'h7F);
      repeat (2) @(negedge clk);
      samp(0);
      chk("abort_busy_pre", 32'(s_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 samp(0);
      chk("abort_busy", 32'(s_busy), 32'd0);
      chk("abort_done", 32'(s_done), 32'd0);
      chk("abort_idx", 32'(s_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_quiet(0, "abort_no_done");
      samp(0);
      chk("abort_le", 32'(s_le), 32'd0);
      chk("abort_eq", 32'(s_eq), 32'd0);
      chk("abort_idx_after", 32'(s_idx), 32'd0);
      chk("abort_busy_after", 32'(s_busy), 32'd0);

      // Early exit at MSB, then an equal pair walking every bit
      run_cmp(1, 8'h3C, 8'hBC, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      run_cmp(1, 8'h55, 8'h55, 9, 1'b1, 1'b1, 1'b1, 1'b0);

      // Fixed latency regardless of where the difference lies
      run_cmp(0, 8'h81, 8'h80, 9, 1'b0, 1'b0, 1'b1, 1'b0);
      run_cmp(0, 8'hF0, 8'hF8, 9, 1'b1, 1'b0, 1'b0, 1'b0);
      run_cmp(0, 8'h55, 8'h55, 9, 1'b1, 1'b1, 1'b0, 1'b0);

      // Operand change and start pulse during scan are ignored
      run_cmp(1, 8'h10, 8'h20, 4, 1'b1, 1'b0, 1'b0, 1'b1);
      count_quiet(1, "no_second_done");

      // Back-to-back: second start on the first idle cycle after done
      run_cmp(1, 8'h3C, 8'hBC, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      run_cmp(1, 8'h01, 8'h00, 9, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmp(1, 8'hA0, 8'hA0, 9, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
